// File: rtl/sccb_pkg.sv
// Shared SCCB definitions: responder FSM states, device ID bytes and OV7670
// register addresses used by both the configuration master and this responder.
package sccb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV_ADDR,
    ST_DEV_ACK,
    ST_SUB_ADDR,
    ST_SUB_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_IGNORE
  } sccb_state_e;

  localparam logic [7:0] SCCB_WR_ID = 8'h42;
  localparam logic [7:0] SCCB_RD_ID = 8'h43;

  // OV7670 register map (subset)
  localparam logic [7:0] OV_CLKRC = 8'h11;
  localparam logic [7:0] OV_COM7  = 8'h12;
  localparam logic [7:0] OV_COM15 = 8'h40;

endpackage

// File: rtl/sccb_line_sync.sv
// SIOC/SIOD synchroniser with edge, START and STOP detection.
// Ports:
//   clk, rst_n  - system clock, async active-low reset
//   scl_in      - raw SIOC from the bus
//   sda_in      - raw SIOD from the bus
//   sda         - synchronised SIOD level
//   scl_rise_c  - 1-clk pulse on SIOC rising edge
//   scl_fall_c  - 1-clk pulse on SIOC falling edge
//   start_c     - 1-clk pulse: SIOD falls while SIOC high
//   stop_c      - 1-clk pulse: SIOD rises while SIOC high
module sccb_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise_c,
  output logic scl_fall_c,
  output logic start_c,
  output logic stop_c
);

  localparam int unsigned STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [STAGES-1:0] scl_sync;
  logic [STAGES-1:0] sda_sync;
  logic              scl_q;
  logic              sda_q;
  logic              scl_s;
  logic              sda_s;

  // Chains reset to the idle-high bus level so leaving reset raises no events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[STAGES-2:0], sda_in};
      scl_q    <= scl_sync[STAGES-1];
      sda_q    <= sda_sync[STAGES-1];
    end
  end

  assign scl_s = scl_sync[STAGES-1];
  assign sda_s = sda_sync[STAGES-1];
  assign sda   = sda_s;

  assign scl_rise_c = scl_s & ~scl_q;
  assign scl_fall_c = ~scl_s & scl_q;
  assign start_c    = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_c     = scl_s & scl_q & ~sda_q & sda_s;

endmodule

// File: rtl/sccb_responder.sv
// SCCB target: decodes START/STOP and device ID, accepts sub-address and data
// writes, returns read data, and drives ACK on an open-drain SIOD.
// Ports:
//   clk, rst_n   - 100 MHz system clock, async active-low reset
//   sioc         - SCCB clock from master
//   siod         - SCCB data, driven 0 or released
//   reg_wr_en    - one-cycle write strobe to the register file
//   reg_wr_addr  - write sub-address
//   reg_wr_data  - write data
//   reg_rd_addr  - current sub-address (read address)
//   reg_rd_data  - register file read data, valid within 2 clk
//   busy         - high from START to STOP
//   addr_match   - one-cycle pulse when the device ID matches
module sccb_responder
  import sccb_pkg::*;
#(
  parameter logic [6:0]  DEV_ID      = SCCB_WR_ID[7:1],
  parameter int unsigned HOLD_CYC    = 10,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sioc,
  inout  wire        siod,
  output logic       reg_wr_en,
  output logic [7:0] reg_wr_addr,
  output logic [7:0] reg_wr_data,
  output logic [7:0] reg_rd_addr,
  input  logic [7:0] reg_rd_data,
  output logic       busy,
  output logic       addr_match
);

  localparam int unsigned HOLD_W   = (HOLD_CYC < 2) ? 1 : $clog2(HOLD_CYC + 1);
  localparam int unsigned HOLD_V   = (HOLD_CYC == 0) ? 1 : HOLD_CYC;
  localparam int unsigned CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(8);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(7);

  sccb_state_e       state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [7:0]        shift;
  logic [7:0]        sub_addr;
  logic              rw;
  logic              rd_acked;
  logic              sda_oe;
  logic              hold_act;
  logic [HOLD_W-1:0] hold_cnt;

  logic              sda;
  logic              scl_rise_c;
  logic              scl_fall_c;
  logic              start_c;
  logic              stop_c;

  logic [7:0]        byte_in;
  logic              shift_en;
  logic              last_bit;
  logic              hold_arm;
  logic              hold_fire;

  sccb_line_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_line_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .scl_in     (sioc),
    .sda_in     (siod),
    .sda        (sda),
    .scl_rise_c (scl_rise_c),
    .scl_fall_c (scl_fall_c),
    .start_c    (start_c),
    .stop_c     (stop_c)
  );

  // Open-drain: only ever pull low.
  assign siod        = sda_oe ? 1'b0 : 1'bz;
  assign reg_rd_addr = sub_addr;

  // Bit shifting qualifiers and hold-delay arming per state.
  always_comb begin
    byte_in   = {shift[6:0], sda};
    shift_en  = scl_rise_c && (bit_cnt != CNT_FULL);
    last_bit  = (bit_cnt == CNT_LAST);
    hold_fire = hold_act && (hold_cnt == HOLD_W'(1));
    hold_arm  = 1'b0;
    if (scl_fall_c) begin
      case (state)
        ST_DEV_ADDR, ST_SUB_ADDR, ST_WDATA:    hold_arm = (bit_cnt == CNT_FULL);
        ST_DEV_ACK, ST_SUB_ACK, ST_WDATA_ACK: hold_arm = 1'b1;
        ST_RDATA:                             hold_arm = (bit_cnt != '0);
        ST_RDATA_ACK:                         hold_arm = rd_acked;
        default:                              hold_arm = 1'b0;
      endcase
    end
  end

  // Responder FSM; SIOD changes only when the hold delay after SIOC fall expires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      shift       <= '0;
      sub_addr    <= '0;
      rw          <= 1'b0;
      rd_acked    <= 1'b0;
      sda_oe      <= 1'b0;
      hold_act    <= 1'b0;
      hold_cnt    <= '0;
      busy        <= 1'b0;
      addr_match  <= 1'b0;
      reg_wr_en   <= 1'b0;
      reg_wr_addr <= '0;
      reg_wr_data <= '0;
    end else begin
      reg_wr_en  <= 1'b0;
      addr_match <= 1'b0;
      if (start_c || stop_c) begin
        // Bus conditions abort any byte in progress, including a partial one.
        state    <= start_c ? ST_DEV_ADDR : ST_IDLE;
        busy     <= start_c;
        bit_cnt  <= '0;
        sda_oe   <= 1'b0;
        hold_act <= 1'b0;
        rd_acked <= 1'b0;
      end else begin
        if (hold_arm) begin
          hold_act <= 1'b1;
          hold_cnt <= HOLD_W'(HOLD_V);
        end else if (hold_fire) begin
          hold_act <= 1'b0;
        end else if (hold_act) begin
          hold_cnt <= hold_cnt - HOLD_W'(1);
        end

        case (state)
          ST_DEV_ADDR: begin
            if (shift_en) begin
              shift   <= byte_in;
              bit_cnt <= bit_cnt + CNT_W'(1);
              if (last_bit) begin
                if (byte_in[7:1] == DEV_ID) begin
                  addr_match <= 1'b1;
                  rw         <= byte_in[0];
                end else begin
                  state <= ST_IGNORE;
                end
              end
            end
            if (hold_fire) begin
              sda_oe <= 1'b1;
              state  <= ST_DEV_ACK;
            end
          end
          ST_DEV_ACK: begin
            if (hold_fire) begin
              bit_cnt <= '0;
              if (rw) begin
                shift  <= reg_rd_data;
                sda_oe <= ~reg_rd_data[7];
                state  <= ST_RDATA;
              end else begin
                sda_oe <= 1'b0;
                state  <= ST_SUB_ADDR;
              end
            end
          end
          ST_SUB_ADDR: begin
            if (shift_en) begin
              shift   <= byte_in;
              bit_cnt <= bit_cnt + CNT_W'(1);
              if (last_bit) sub_addr <= byte_in;
            end
            if (hold_fire) begin
              sda_oe <= 1'b1;
              state  <= ST_SUB_ACK;
            end
          end
          ST_SUB_ACK, ST_WDATA_ACK: begin
            if (hold_fire) begin
              sda_oe  <= 1'b0;
              bit_cnt <= '0;
              state   <= ST_WDATA;
            end
          end
          ST_WDATA: begin
            if (shift_en) begin
              shift   <= byte_in;
              bit_cnt <= bit_cnt + CNT_W'(1);
              if (last_bit) begin
                reg_wr_en   <= 1'b1;
                reg_wr_addr <= sub_addr;
                reg_wr_data <= byte_in;
              end
            end
            if (hold_fire) begin
              sda_oe   <= 1'b1;
              sub_addr <= sub_addr + 8'd1;
              state    <= ST_WDATA_ACK;
            end
          end
          ST_RDATA: begin
            if (shift_en) bit_cnt <= bit_cnt + CNT_W'(1);
            if (hold_fire) begin
              if (bit_cnt == CNT_FULL) begin
                sda_oe <= 1'b0;
                state  <= ST_RDATA_ACK;
              end else begin
                shift  <= {shift[6:0], 1'b0};
                sda_oe <= ~shift[6];
              end
            end
          end
          ST_RDATA_ACK: begin
            if (scl_rise_c && !rd_acked) begin
              if (!sda) begin
                rd_acked <= 1'b1;
                sub_addr <= sub_addr + 8'd1;
              end else begin
                state <= ST_IGNORE;
              end
            end
            if (hold_fire) begin
              rd_acked <= 1'b0;
              bit_cnt  <= '0;
              shift    <= reg_rd_data;
              sda_oe   <= ~reg_rd_data[7];
              state    <= ST_RDATA;
            end
          end
          ST_IGNORE: sda_oe <= 1'b0;
          default:   state  <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/sccb_responder.md
Name: sccb_responder

Overview:
- SCCB/I2C target (responder) for the camera configuration bus: the receiving end of the OV7670 register-write master.
- Decodes START/STOP and device ID, then accepts sub-address and data writes or returns read data, and drives ACK.
- Exposes a simple register-port interface to an external 256x8 register file.
- Used as an on-FPGA camera stand-in for board bring-up and as a synthesizable bus model in simulation.

Parameters:
- DEV_ID, 7'h21, 7-bit device address (write byte 8'h42, read byte 8'h43).
- HOLD_CYC, 10, clk cycles after a detected SIOC falling edge before SIOD drive changes (data hold).
- SYNC_STAGES, 2, synchroniser depth on SIOC/SIOD inputs (minimum 2).

Ports:
- clk  in  1  100 MHz system clock
- rst_n  in  1  asynchronous active-low reset
- sioc  in  1  SCCB clock from master; SIOC max 400 kHz
- siod  inout  1  SCCB data; open-drain: driven 0 or released to 'z', never driven 1
- reg_wr_en  out  1  one-cycle write strobe
- reg_wr_addr  out  8  write sub-address
- reg_wr_data  out  8  write data
- reg_rd_addr  out  8  current sub-address for reads
- reg_rd_data  in  8  read data for reg_rd_addr, valid within 2 clk
- busy  out  1  high from START to STOP
- addr_match  out  1  one-cycle pulse when device ID matches

Behaviour:
- Reset (async, rst_n=0): all outputs 0, siod released, sub-address 8'h00, FSM in IDLE.
- Inputs pass through SYNC_STAGES flops, then one edge-detect flop. Events:
  - START: SIOD falls while SIOC=1.
  - STOP: SIOD rises while SIOC=1.
  - Bit sampling: SIOD sampled on SIOC rising edge.
- START or STOP is recognised in any state and overrides the bit activity in progress.
  - START, including a repeated START: go to DEV_ADDR, set busy=1, bit counter=0, release siod.
  - STOP: go to IDLE, set busy=0, release siod.
- FSM states: IDLE, DEV_ADDR, DEV_ACK, SUB_ADDR, SUB_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- DEV_ADDR: shift 8 bits MSB first.
  - Bits[7:1]==DEV_ID: pulse addr_match; on the next SIOC fall + HOLD_CYC, drive siod=0 (ACK) and go to DEV_ACK.
  - Mismatch: go to IGNORE with siod released; stay there until START/STOP.
- DEV_ACK: release siod on the following SIOC fall + HOLD_CYC.
  - R/W=0: go to SUB_ADDR.
  - R/W=1: go to RDATA, latching reg_rd_data into the shift register at the same time.
- SUB_ADDR: 8 bits, then latch the sub-address, ACK, go to WDATA.
  - A 2-phase write (STOP here) only sets the sub-address.
- WDATA: 8 bits, then reg_wr_en=1 for exactly one clk with reg_wr_addr=sub-address.
  - Then ACK, increment the sub-address (wraps 8'hFF->8'h00), return to WDATA for burst writes.
- RDATA: siod drives (shift[7]==0 ? 0 : z), with each bit updated at SIOC fall + HOLD_CYC. The first bit goes out at the DEV_ACK release point.
  - After 8 bits, release siod and go to RDATA_ACK, which samples the master ACK.
  - ACK (0): increment the sub-address, load the next byte, return to RDATA.
  - NACK (1): go to IGNORE.
- reg_rd_addr always equals the current sub-address.
- Glitch or early STOP mid-byte: the partial byte is discarded and no strobe is issued.

Decomposition:
- Shared package sccb_pkg:
  - state enum;
  - SCCB_WR_ID = 8'h42 and SCCB_RD_ID = 8'h43;
  - OV7670 register address constants (COM7 8'h12, CLKRC 8'h11, COM15 8'h40, ...), shared with the configuration master.
- Sub-module sccb_line_sync: synchroniser plus edge/START/STOP detector with 1-clk event pulses.
- The top holds the FSM, the shift register and the hold-delay counter.

Test Plan:
- 3-phase write 42/12/04 at 200 kHz -> one reg_wr_en with addr 8'h12, data 8'h04; ACK=0 seen on all three ACK slots; busy drops after STOP.
- Burst 42/70/3A/35/11 -> writes 70=3A, 71=35, 72=11; sub-address ends at 8'h73.
- 2-phase write 42/0A then START/43 with reg_rd_data model 8'h76 at 0A, 8'h73 at 0B, master ACK then NACK -> bytes 76, 73 on siod; then IGNORE; no reg_wr_en.
- Wrong ID 8'h44 -> siod never driven, no addr_match, no reg_wr_en; a following 42/11/00 transaction is accepted.
- Burst write starting at sub-address 8'hFF with 2 data bytes -> writes at FF then 00.
- rst_n asserted mid-WDATA (bit 4) -> siod released immediately, no strobe; after release, the next 42/3E/19 write succeeds.
